shift_register_n: RTL
=====================

# shift_register_n

Parametrised universal shift register, the successor to the fixed 8-bit four-mode register used in the lab designs. It adds generic width, rotate and arithmetic-shift modes, a synchronous clear, and carry-out capture. It also provides a multi-step burst engine: one START shifts the word AMT positions, with BUSY/DONE handshaking. It sits between datapath registers and serial I/O blocks, or anywhere a counted shift sequence is needed without an external counter.

## Interface
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- AW, $clog2(WIDTH+1), local (derived) width of the AMT field.
- CP  in  1  clock; all state updates on the rising edge.
- CR  in  1  asynchronous, active-high reset.
- EN  in  1  clock enable. When 0: no state change, except DONE→IDLE.
- M  in  3  mode select (see Operation).
- DSR  in  1  serial input for logical shift right (enters the MSB).
- DSL  in  1  serial input for shift left (enters the LSB).
- D  in  WIDTH  parallel load data.
- START  in  1  burst request; sampled only in IDLE.
- AMT  in  AW  burst step count; values above WIDTH are clamped to WIDTH.
- Q  out  WIDTH  register contents.
- CO  out  1  last bit shifted or rotated out.
- BUSY  out  1  high while in the RUN state.
- DONE  out  1  one-cycle pulse at burst completion.

## Operation
- Modes, as one step of Q:
  - 000 hold.
  - 001 SR: Q ← {DSR, Q[W-1:1]}; CO ← Q[0].
  - 010 SL: Q ← {Q[W-2:0], DSL}; CO ← Q[W-1].
  - 011 load: Q ← D; CO unchanged.
  - 100 ROR: Q ← {Q[0], Q[W-1:1]}; CO ← Q[0].
  - 101 ROL: Q ← {Q[W-2:0], Q[W-1]}; CO ← Q[W-1].
  - 110 ASR: Q ← {Q[W-1], Q[W-1:1]}; CO ← Q[0].
  - 111 clear: Q ← 0; CO ← 0.
- Shift-class modes are 001, 010, 100, 101 and 110.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - EN=1 and START=0: perform one step of M.
  - EN=1, START=1, M shift-class: latch M into mode_r and clamp(AMT) into cnt, with no step at this edge. Go to RUN if cnt≠0, else go to DONE.
  - EN=1, START=1, M not shift-class: START is ignored; a normal single step of M is performed.
- RUN:
  - Each edge with EN=1 performs one step of mode_r and decrements cnt. When cnt becomes 0, go to DONE.
  - EN=0 pauses the burst: Q, cnt and state hold.
  - The external M, D, AMT and START inputs are ignored. DSR and DSL are sampled live at each step.
- DONE: DONE=1 for exactly one cycle, then IDLE unconditionally, regardless of EN. START is ignored in this state.
- Reset (CR=1), at any time including mid-burst: Q=0, CO=0, cnt=0, state=IDLE, BUSY=0, DONE=0. The burst is abandoned.
- Clamp: AMT > WIDTH is treated as WIDTH. An 8-step ROR is therefore the identity, with CO = the original Q[7].

## Timing
- Single-step modes: Q and CO update at the sampling edge; latency is 1 cycle.
- Burst, START accepted at edge e0:
  - BUSY=1 from e0 until the edge of the final step.
  - Steps occur at edges e1..eN, where N = AMT plus the number of EN=0 cycles.
  - DONE=1 during the cycle after eN; IDLE after eN+1.
- AMT=0: DONE=1 in the cycle after e0, with Q unchanged; BUSY never asserts.
- BUSY and DONE are never high in the same cycle; both are registered (state-decoded).
- Minimum spacing between bursts is AMT+2 edges.

## Structure
- Package shift_register_n_pkg holds:
  - mode localparams: M_HOLD, M_SR, M_SL, M_LOAD, M_ROR, M_ROL, M_ASR, M_CLR;
  - the state encoding: S_IDLE, S_RUN, S_DONE;
  - an is_shift_mode() function.
- Sub-module shift_step_n (combinational): inputs mode, Q, DSR, DSL, D; outputs next Q, next CO, co_valid. It is shared by the single-step and burst paths.
- The top level holds the FSM, cnt, mode_r and the output registers.

## Test plan
- Single-step sequence, WIDTH=8:
  - CR pulse → Q=8'h00, BUSY=0, DONE=0.
  - Load D=8'b1000_0000 → Q=8'h80.
  - SL with DSL=0 → Q=8'h00, CO=1.
- Burst ROR, AMT=3, from Q=8'h80: BUSY for 3 cycles; Q=8'h10, CO=0; DONE pulses once in the next cycle.
- Burst ASR, AMT=4, from 8'h80 → Q=8'hF8. Burst SR, AMT=4, DSR=1, from 8'h00 → Q=8'hF0.
- Burst ROL, AMT=15 (clamped to 8), from 8'hA5: 8 BUSY cycles; Q=8'hA5, CO=1.
- EN=0 for 2 cycles mid-burst (SL, AMT=4): Q holds during the pause; total BUSY = 6 cycles; final Q is correct.
- Boundary cases:
  - START with AMT=0 → DONE next cycle, no BUSY.
  - START with M=011 → plain load, no burst.
  - CR asserted mid-burst → Q=0, IDLE immediately; a following burst behaves normally.

Source files
------------

// File: rtl/shift_register_n_pkg.sv
// Shared mode codes, FSM state encoding and mode classification for the
// parametrised universal shift register.
package shift_register_n_pkg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SR   = 3'b001;
    localparam logic [2:0] M_SL   = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Only these modes move bits, so only they may start a burst.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == M_SR) || (m == M_SL) || (m == M_ROR) ||
               (m == M_ROL) || (m == M_ASR);
    endfunction

endpackage

// File: rtl/shift_register_n_step.sv
// Combinational single-step datapath: computes the next register word and
// carry-out for one application of a mode.
module shift_step_n
    import shift_register_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             co_next,
    output logic             co_valid
);

    always_comb begin
        q_next   = q;
        co_next  = 1'b0;
        co_valid = 1'b0;
        case (mode)
            M_SR: begin
                q_next   = {dsr, q[WIDTH-1:1]};
                co_next  = q[0];
                co_valid = 1'b1;
            end
            M_SL: begin
                q_next   = {q[WIDTH-2:0], dsl};
                co_next  = q[WIDTH-1];
                co_valid = 1'b1;
            end
            M_LOAD: begin
                q_next = d;
            end
            M_ROR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                co_next  = q[0];
                co_valid = 1'b1;
            end
            M_ROL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                co_next  = q[WIDTH-1];
                co_valid = 1'b1;
            end
            M_ASR: begin
                q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                co_next  = q[0];
                co_valid = 1'b1;
            end
            M_CLR: begin
                q_next   = '0;
                co_next  = 1'b0;
                co_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_register_n.sv
// Universal shift register with single-step modes and a counted burst engine
// (START shifts AMT positions with BUSY/DONE handshaking).
module shift_register_n
    import shift_register_n_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH + 1)
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             EN,
    input  logic [2:0]       M,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [AW-1:0]    AMT,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_co;
    logic             step_co_valid;
    logic [AW-1:0]    amt_clamped;

    assign amt_clamped = (AMT > AMT_MAX) ? AMT_MAX : AMT;
    // A running burst ignores the external mode and replays the latched one.
    assign step_mode   = (state_q == S_RUN) ? mode_q : M;

    shift_step_n #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .q        (q_q),
        .dsr      (DSR),
        .dsl      (DSL),
        .d        (D),
        .q_next   (step_q),
        .co_next  (step_co),
        .co_valid (step_co_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        co_d    = co_q;
        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    if (START && is_shift_mode(M)) begin
                        mode_d  = M;
                        cnt_d   = amt_clamped;
                        state_d = (amt_clamped != '0) ? S_RUN : S_DONE;
                    end else begin
                        q_d = step_q;
                        if (step_co_valid) co_d = step_co;
                    end
                end
            end
            S_RUN: begin
                if (EN) begin
                    q_d = step_q;
                    if (step_co_valid) co_d = step_co;
                    cnt_d = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            q_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            co_q    <= co_d;
        end
    end

    assign Q    = q_q;
    assign CO   = co_q;
    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_DONE);

endmodule
